fft_input_loader: RTL and testbench

//  Upstream stage of fft1024. Accepts a stream of N complex time-domain samples,

---
 rtl/fft_input_loader_if.sv | 11 +
 rtl/fft_input_loader.sv | 143 ++++++++++++++
 tb/tb_fft_input_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_loader_if.sv
// rtl/fft_input_loader_if.sv - sample stream handshake into the FFT input loader
interface fft_input_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - bit-reversed frame loader and sequencer for fft1024 banks
module fft_input_loader #(
    parameter int N      = 1024,
    parameter int LOG2N  = 10,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    fft_input_loader_if.slave s,
    output logic              ce0,
    output logic              wre0,
    output logic              oce0,
    output logic [ADDR_W-1:0] ad0,
    output logic [DATA_W-1:0] din0,
    output logic              ce1,
    output logic              wre1,
    output logic              oce1,
    output logic [ADDR_W-1:0] ad1,
    output logic [DATA_W-1:0] din1,
    output logic              sel,
    output logic              fft_start,
    input  logic              fft_finish,
    output logic              done,
    input  logic              bank_release
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, HOLD} state_t;

    state_t            state, state_n;
    logic [LOG2N-1:0]  cnt, cnt_n;
    logic [LOG2N-1:0]  rev;
    logic [ADDR_W-1:0] addr;
    logic              accept, last;
    logic              s_ready_q, s_ready_n;
    logic              ce0_n, ce1_n, sel_n, start_n, done_n;
    logic [ADDR_W-1:0] ad0_n, ad1_n;
    logic [DATA_W-1:0] din0_n, din1_n;

    // The loader never reads the banks, so output clock enables stay low.
    assign oce0      = 1'b0;
    assign oce1      = 1'b0;
    assign wre0      = ce0;
    assign wre1      = ce1;
    assign s.s_ready = s_ready_q;

    assign accept = s.s_valid & s_ready_q;
    assign last   = (cnt == LOG2N'(N - 1));

    // Bit-reverse the sample index; the top reversed bit picks the bank.
    always_comb begin
        rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rev[i] = cnt[LOG2N-1-i];
        end
        addr = {{(ADDR_W-LOG2N+1){1'b0}}, rev[LOG2N-2:0]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: load a frame, kick the FFT, wait, hold for the reader.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = last ? START : LOAD;
            LOAD:    if (accept && last) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (fft_finish) state_n = HOLD;
            HOLD:    if (bank_release) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values for the registered bank ports and control pulses.
    always_comb begin
        ce0_n     = 1'b0;
        ce1_n     = 1'b0;
        ad0_n     = ad0;
        ad1_n     = ad1;
        din0_n    = din0;
        din1_n    = din1;
        cnt_n     = cnt;
        sel_n     = sel;
        start_n   = (state == START);
        done_n    = 1'b0;
        s_ready_n = (state_n == IDLE) || (state_n == LOAD);
        if (accept) begin
            cnt_n = last ? '0 : cnt + 1'b1;
            if (rev[LOG2N-1]) begin
                ce1_n  = 1'b1;
                ad1_n  = addr;
                din1_n = s.s_data;
            end else begin
                ce0_n  = 1'b1;
                ad0_n  = addr;
                din0_n = s.s_data;
            end
        end
        if (state == START) begin
            sel_n = 1'b1;
        end else if (state == WAIT && fft_finish) begin
            sel_n  = 1'b0;
            done_n = 1'b1;
        end
    end

    // Output and counter registers; reset drops any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            s_ready_q <= 1'b0;
            ce0       <= 1'b0;
            ce1       <= 1'b0;
            ad0       <= '0;
            ad1       <= '0;
            din0      <= '0;
            din1      <= '0;
            sel       <= 1'b0;
            fft_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            s_ready_q <= s_ready_n;
            ce0       <= ce0_n;
            ce1       <= ce1_n;
            ad0       <= ad0_n;
            ad1       <= ad1_n;
            din0      <= din0_n;
            din1      <= din1_n;
            sel       <= sel_n;
            fft_start <= start_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - self-checking bench for fft_input_loader
module tb_fft_input_loader;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce0, wre0, oce0, ce1, wre1, oce1;
    logic [10:0] ad0, ad1;
    logic [31:0] din0, din1;
    logic        sel, fft_start, fft_finish, done, bank_release;

    int n_tests = 0;
    int n_fail  = 0;

    fft_input_loader_if #(.DATA_W(32)) sif ();

    fft_input_loader dut (
        .clk          (clk),
        .rst          (rst),
        .s            (sif),
        .ce0          (ce0),
        .wre0         (wre0),
        .oce0         (oce0),
        .ad0          (ad0),
        .din0         (din0),
        .ce1          (ce1),
        .wre1         (wre1),
        .oce1         (oce1),
        .ad1          (ad1),
        .din1         (din1),
        .sel          (sel),
        .fft_start    (fft_start),
        .fft_finish   (fft_finish),
        .done         (done),
        .bank_release (bank_release)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: frame position, phase and expected outputs per cycle.
    typedef enum int {P_LOAD, P_START, P_WAIT, P_HOLD} phase_e;
    phase_e      ph;
    int          mcnt;
    bit          e_ready, e_sel, e_start, e_done, e_wr;
    int          e_bank, e_addr;
    logic [31:0] e_data;
    int          hits [2][512];
    int          nwrites;

    function automatic int bit_reverse(int v);
        int r = 0;
        for (int b = 0; b < 10; b++) begin
            if (((v >> b) & 1) != 0) r += 1 << (9 - b);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outs", {ce0, wre0, ce1, wre1, sel, fft_start, done, sif.s_ready}, 0);
            chk("rst_bus", {ad0, ad1, din0, din1}, 0);
            ph = P_LOAD; mcnt = 0;
            e_ready = 1; e_sel = 0; e_start = 0; e_done = 0; e_wr = 0;
        end else begin
            bit     n_ready, n_sel, n_start, n_done, n_wr;
            phase_e n_ph;
            chk("s_ready", sif.s_ready, e_ready);
            chk("sel", sel, e_sel);
            chk("fft_start", fft_start, e_start);
            chk("done", done, e_done);
            chk("oce", {oce0, oce1}, 0);
            if (e_wr) begin
                if (e_bank == 1) chk("wr_en_b1", {ce1, wre1, ce0, wre0}, 4'b1100);
                else             chk("wr_en_b0", {ce0, wre0, ce1, wre1}, 4'b1100);
                chk("wr_addr", e_bank == 1 ? ad1 : ad0, e_addr);
                chk("wr_data", e_bank == 1 ? din1 : din0, e_data);
            end else begin
                chk("wr_idle", {ce0, wre0, ce1, wre1}, 0);
            end
            if (ce0 && wre0) begin
                if (ad0 < 512) hits[0][ad0]++;
                nwrites++;
            end
            if (ce1 && wre1) begin
                if (ad1 < 512) hits[1][ad1]++;
                nwrites++;
            end
            n_ready = e_ready; n_sel = e_sel; n_start = 0; n_done = 0; n_wr = 0; n_ph = ph;
            case (ph)
                P_LOAD: if (sif.s_valid && e_ready) begin
                    int r;
                    r = bit_reverse(mcnt);
                    n_wr = 1; e_bank = r / 512; e_addr = r % 512; e_data = sif.s_data;
                    mcnt++;
                    if (mcnt == N) begin
                        mcnt = 0; n_ph = P_START; n_ready = 0;
                    end
                end
                P_START: begin n_ph = P_WAIT; n_start = 1; n_sel = 1; end
                P_WAIT:  if (fft_finish) begin n_ph = P_HOLD; n_sel = 0; n_done = 1; end
                P_HOLD:  if (bank_release) begin n_ph = P_LOAD; n_ready = 1; end
                default: n_ph = P_LOAD;
            endcase
            e_ready = n_ready; e_sel = n_sel; e_start = n_start; e_done = n_done;
            e_wr = n_wr; ph = n_ph;
        end
    end

    typedef struct {
        logic [31:0] data;
        int          bank;
        int          addr;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_cov();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) hits[b][a] = 0;
        nwrites = 0;
    endtask

    task automatic check_cov(string tag);
        int ones0 = 0, ones1 = 0;
        for (int a = 0; a < 512; a++) begin
            if (hits[0][a] == 1) ones0++;
            if (hits[1][a] == 1) ones1++;
        end
        chk({tag, "_cov_b0"}, ones0, 512);
        chk({tag, "_cov_b1"}, ones1, 512);
        chk({tag, "_nwrites"}, nwrites, N);
    endtask

    task automatic send(int first, int count, bit gaps, bit rnd);
        for (int k = 0; k < count; k++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                sif.s_valid = 1'b0;
                sif.s_data  = $urandom;
                tick();
            end
            sif.s_valid = 1'b1;
            sif.s_data  = rnd ? 32'($urandom) : 32'(first + k);
            tick();
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_start(string tag);
        int k = 0;
        while (!fft_start && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_start_seen"}, fft_start, 1);
    endtask

    initial begin
        tbl[0] = '{32'hA000_0000, 0, 0};
        tbl[1] = '{32'hA000_0001, 1, 0};
        tbl[2] = '{32'hA000_0002, 0, 256};
        tbl[3] = '{32'hA000_0003, 1, 256};
        tbl[4] = '{32'hA000_0004, 0, 128};
        tbl[5] = '{32'hA000_0005, 1, 128};
        tbl[6] = '{32'hA000_0006, 0, 384};
        tbl[7] = '{32'hA000_0007, 1, 384};

        rst = 1'b1; sif.s_valid = 1'b0; sif.s_data = '0;
        fft_finish = 1'b0; bank_release = 1'b0;
        clear_cov();
        repeat (3) tick();
        chk("t1_ready_in_rst", sif.s_ready, 0);
        @(negedge clk); #1 rst = 1'b0;
        tick();
        chk("t1_ready_after", sif.s_ready, 1);
        chk("t1_ports", {ce0, wre0, ce1, wre1, sel, fft_start, done}, 0);

        // Table-driven first writes of a frame.
        for (int i = 0; i < 8; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = tbl[i].data;
            tick();
            if (tbl[i].bank == 0) begin
                chk("t2_en", {ce0, wre0, ce1, wre1}, 4'b1100);
                chk("t2_ad", ad0, tbl[i].addr);
                chk("t2_din", din0, tbl[i].data);
            end else begin
                chk("t2_en", {ce1, wre1, ce0, wre0}, 4'b1100);
                chk("t2_ad", ad1, tbl[i].addr);
                chk("t2_din", din1, tbl[i].data);
            end
        end

        // Rest of the frame as a back-to-back ramp, then start latency.
        send(8, N - 8, 1'b0, 1'b0);
        chk("t3_ready_low", sif.s_ready, 0);
        chk("t3_last_wr", {ce1, wre1, ad1, sel, fft_start}, {2'b11, 11'd511, 2'b00});
        chk("t3_last_din", din1, N - 1);
        tick();
        chk("t3_start", {fft_start, sel}, 2'b11);
        sif.s_valid = 1'b1;
        sif.s_data  = 32'hDEAD_BEEF;
        tick();
        chk("t3_start_once", {fft_start, sel}, 2'b01);
        check_cov("t3");

        // fft_finish with a simultaneous release; only finish acts.
        repeat (4) tick();
        fft_finish = 1'b1; bank_release = 1'b1;
        tick();
        chk("t5_done", {done, sel, sif.s_ready}, 3'b100);
        fft_finish = 1'b0; bank_release = 1'b0;
        repeat (3) tick();
        chk("t5_hold", {done, sel, sif.s_ready, ce0, ce1}, 0);
        sif.s_valid = 1'b0;
        bank_release = 1'b1;
        tick();
        bank_release = 1'b0;
        chk("t5_rearm", sif.s_ready, 1);
        clear_cov();

        // Second frame: random gaps and data, starts again from index 0.
        sif.s_valid = 1'b1; sif.s_data = 32'h1234_5678;
        tick();
        chk("t5_f2_first", {ce0, wre0, ad0, din0}, {2'b11, 11'd0, 32'h1234_5678});
        send(1, N - 1, 1'b1, 1'b1);
        wait_start("t4");
        check_cov("t4");
        sif.s_valid = 1'b1;
        repeat ($urandom_range(1, 8)) tick();
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        chk("t4_done", done, 1);
        repeat ($urandom_range(1, 5)) tick();
        sif.s_valid = 1'b0;
        bank_release = 1'b1;
        tick();
        bank_release = 1'b0;

        // Reset in the middle of a frame.
        send(0, 300, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_now", {ce0, wre0, ce1, wre1, sel, fft_start, done, sif.s_ready}, 0);
        @(negedge clk); #1 rst = 1'b0;
        tick();
        chk("t6_ready", sif.s_ready, 1);
        sif.s_valid = 1'b1; sif.s_data = 32'hCAFE_0001;
        tick();
        sif.s_valid = 1'b0;
        chk("t6_first", {ce0, wre0, ad0, din0, ce1}, {2'b11, 11'd0, 32'hCAFE_0001, 1'b0});
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
